// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Build option: FETCH_BYPASS_EN (see instruction_fetch_queue.sv).
package fetch_pkg;

    localparam int unsigned FETCH_INSTR_W   = 16;
    localparam int unsigned FETCH_ADDR_W    = 32;
    localparam int unsigned FETCH_MEM_DEPTH = 512;
    localparam int unsigned INSTR_STEP      = 2;
    localparam int unsigned FETCH_IDX_W     = $clog2(FETCH_MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FETCH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_queue_ram.sv
// Single-port instruction RAM: synchronous write, registered read (1-cycle latency).
module fetch_ram_sp #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Prefetching instruction fetch stage: RAM + prefetch queue + valid/ready decode port.
// Build option: define FETCH_BYPASS_EN to forward returning RAM data straight to an empty queue's output.
module instruction_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned INSTR_W     = FETCH_INSTR_W,
    parameter int unsigned ADDR_W      = FETCH_ADDR_W,
    parameter int unsigned MEM_DEPTH   = FETCH_MEM_DEPTH,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_en_i,
    input  logic [ADDR_W-1:0]  load_addr_i,
    input  logic [INSTR_W-1:0] load_data_i,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  start_addr_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  redirect_addr_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               busy_o
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_state_e state, state_nxt;

    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_pc;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [INSTR_W-1:0] q_instr [QUEUE_DEPTH];
    logic [ADDR_W-1:0]  q_pc    [QUEUE_DEPTH];

    logic               restart;
    logic               pc_set;
    logic [ADDR_W-1:0]  pc_set_val;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               bypass_hit;
    logic               pop, q_pop, push, rd_en;
    logic [CNT_W:0]     occ_next;
    logic [IDX_W-1:0]   ram_addr;
    logic [INSTR_W-1:0] ram_rdata;
    logic               unused_addr_bits;

    assign redirect_pc      = {redirect_addr_i[ADDR_W-1:1], 1'b0};
    assign unused_addr_bits = ^{load_addr_i[ADDR_W-1:IDX_W+1], load_addr_i[0], redirect_addr_i[0]};

    // Next state; restart = start/flush that empties the queue and redirects fetching
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_FETCH;
                    restart   = 1'b1;
                end
            end
            S_LOAD:  state_nxt = S_IDLE;
            S_FETCH: restart   = start_i || flush_i;
            default: state_nxt = S_IDLE;
        endcase
        if (load_en_i) begin
            state_nxt = S_LOAD;
            restart   = 1'b0;
        end
    end

    assign pc_set     = restart || (!load_en_i && flush_i);
    assign pc_set_val = (restart && start_i) ? start_addr_i : redirect_pc;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = inflight && (count == '0) && !load_en_i;
`else
    assign bypass_hit = 1'b0;
`endif

    // Head of queue, or forwarded RAM data when the queue is empty
    always_comb begin
        valid_o = (count != '0);
        instr_o = '0;
        pc_o    = '0;
        if (count != '0) begin
            instr_o = q_instr[rd_ptr];
            pc_o    = q_pc[rd_ptr];
        end else if (bypass_hit) begin
            valid_o = 1'b1;
            instr_o = ram_rdata;
            pc_o    = inflight_pc;
        end
    end

    assign busy_o   = (state == S_FETCH);
    assign pop      = valid_o && ready_i;
    assign q_pop    = pop && (count != '0);
    assign push     = inflight && !load_en_i && !restart && !(bypass_hit && ready_i);
    assign occ_next = {1'b0, count} + (CNT_W+1)'(push) - (CNT_W+1)'(q_pop);
    assign rd_en    = (state == S_FETCH) && !load_en_i && !restart
                      && (occ_next < (CNT_W+1)'(QUEUE_DEPTH));
    assign ram_addr = load_en_i ? load_addr_i[IDX_W:1] : fetch_pc[IDX_W:1];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= S_IDLE;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fetch_pc    <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_en;
            if (rd_en) begin
                inflight_pc <= fetch_pc;
            end
            if (pc_set) begin
                fetch_pc <= pc_set_val;
            end else if (rd_en) begin
                fetch_pc <= fetch_pc + ADDR_W'(INSTR_STEP);
            end
            if (load_en_i || restart) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= CNT_W'(occ_next);
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (q_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Queue storage needs no reset: entries are only read when count covers them
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_instr[wr_ptr] <= ram_rdata;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(push && !q_pop && (count == CNT_W'(QUEUE_DEPTH))));

    fetch_ram_sp #(
        .DATA_W (INSTR_W),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk_i),
        .rst_n (reset_n_i),
        .we    (load_en_i),
        .re    (rd_en),
        .addr  (ram_addr),
        .wdata (load_data_i),
        .rdata (ram_rdata)
    );

endmodule
